mem_req_arbiter: RTL
====================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 2, giving the number of accepted-but-unanswered transactions allowed (power of two, ≥1).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 The block SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port inst_req, input, 1, fetch read request.
REQ-005 The block SHALL have port inst_addr, input, 32, fetch address.
REQ-006 The block SHALL have port inst_addr_ok, output, 1, fetch request accepted this cycle.
REQ-007 The block SHALL have port inst_data_ok, output, 1, fetch response valid this cycle.
REQ-008 The block SHALL have port inst_rdata, output, 32, fetch read data.
REQ-009 The block SHALL have port data_req, input, 1, load/store request.
REQ-010 The block SHALL have port data_size, input, 2, access size (0=byte, 1=half, 2=word).
REQ-011 The block SHALL have port data_wstrb, input, 4, byte strobes; nonzero means write.
REQ-012 The block SHALL have port data_addr, input, 32, load/store address.
REQ-013 The block SHALL have port data_wdata, input, 32, store data.
REQ-014 The block SHALL have ports data_addr_ok/data_data_ok (output, 1) and data_rdata (output, 32), with the inst_* meanings.
REQ-015 The block SHALL have ports mem_req (output, 1), mem_size (output, 2), mem_wstrb (output, 4), mem_addr (output, 32) and mem_wdata (output, 32): the shared request channel.
REQ-016 The block SHALL have ports mem_addr_ok (input, 1), mem_data_ok (input, 1) and mem_rdata (input, 32): the shared memory handshake and data.

Function
REQ-017 The block SHALL generate mem_req = (inst_req | data_req) & ~order_full & ~reset, combinationally, with zero added cycles.
REQ-018 Inst requests SHALL drive mem_size=2 and mem_wstrb=0; selected data requests SHALL pass size, wstrb, addr and wdata through unchanged.
REQ-019 Acceptance SHALL be mem_req & mem_addr_ok, and SHALL raise exactly one of inst_addr_ok or data_addr_ok, for the selected requester.
REQ-020 Once mem_req is high and not yet accepted, a lock register SHALL hold the selection until acceptance; a newly rising competing request SHALL NOT switch it.
REQ-021 On acceptance, the owner bit (0=inst, 1=data) SHALL be pushed into an in-order FIFO of MAX_OUTSTANDING entries; writes SHALL be pushed too.
REQ-022 On mem_data_ok with the FIFO non-empty, the block SHALL pop the head and assert the owner's *_data_ok in the same cycle; mem_rdata SHALL be broadcast to both *_rdata.
REQ-023 A mem_data_ok arriving with the FIFO empty SHALL be ignored: no *_data_ok and no pointer change.
REQ-024 A simultaneous push and pop SHALL leave the count unchanged; full SHALL be evaluated on the registered count, so a pop does not unblock mem_req in the same cycle.
REQ-025 Pointers SHALL wrap modulo MAX_OUTSTANDING; the count SHALL range 0..MAX_OUTSTANDING.

Reset
REQ-026 While resetn=0 at a clock edge, the FIFO SHALL be emptied, the lock cleared and the RR pointer set to inst; mem_req, all *_addr_ok and all *_data_ok SHALL be 0 during reset.
REQ-027 A reset during outstanding transactions SHALL discard them; late mem_data_ok SHALL then follow REQ-023.

Configuration
REQ-028 With ARB_RR_EN defined, a tie SHALL grant the requester not granted last (round robin, updated on acceptance); without it, a tie SHALL always grant data (fixed priority).

Structure
REQ-029 Shared package mem_arb_pkg SHALL hold OWNER_INST/OWNER_DATA and the size encodings SIZE_B/SIZE_H/SIZE_W.
REQ-030 The owner FIFO SHALL be sub-module arb_order_fifo (push, pop, full, empty, head).

Verification
REQ-031 Both requesting at reset exit, mem_addr_ok=1: data accepted first (fixed) or inst first (ARB_RR_EN), then the other one cycle later.
REQ-032 inst_req at 0x1C000000, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 1: mem_addr stays 0x1C000000 until accepted.
REQ-033 Two accepts (inst, data) with MAX_OUTSTANDING=2: mem_req=0 on a third request; mem_data_ok with rdata 0x11 then 0x22 gives inst_data_ok (0x11), then data_data_ok (0x22).
REQ-034 Store with wstrb=4'b0011, size=1, addr 0x8: passed unchanged to mem_*; its mem_data_ok gives data_data_ok only.
REQ-035 mem_data_ok pulsed while empty: no *_data_ok; resetn=0 with 1 outstanding: the later response is dropped.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : mem_arb_pkg                                            |
// | Description : Shared encodings for the memory request arbiter:       |
// |               requester owner codes, access size codes and the       |
// |               request-lock state encoding.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  // Owner of a transaction as recorded in the in-order response FIFO.
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Access size encodings carried on *_size / mem_size.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Request-lock state: which requester owns an issued-but-unaccepted
  // request on the shared channel.
  localparam int         LOCK_W    = 2;
  localparam logic [1:0] LOCK_IDLE = 2'd0;
  localparam logic [1:0] LOCK_INST = 2'd1;
  localparam logic [1:0] LOCK_DATA = 2'd2;

  // Lock state that pins the channel to the given owner.
  function automatic logic [LOCK_W-1:0] lock_state_for(input logic owner);
    return (owner == OWNER_DATA) ? LOCK_DATA : LOCK_INST;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_order_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : arb_order_fifo                                         |
// | Description : In-order FIFO of 1-bit owner tags. Each accepted       |
// |               memory request pushes its owner; each memory response  |
// |               pops the head so the response is steered back to the   |
// |               requester that issued it.                              |
// | Ports       : clk          - clock, rising edge                      |
// |               resetn       - synchronous active-low reset            |
// |               push_i       - push push_owner_i (ignored when full)   |
// |               push_owner_i - owner tag to store                      |
// |               pop_i        - drop the head entry (ignored when empty)|
// |               full_o       - registered count equals DEPTH           |
// |               empty_o      - registered count is zero                |
// |               head_o       - owner tag at the head                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module arb_order_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic push_owner_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [DEPTH-1:0] slot_q, slot_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic w_push;
  logic w_pop;

  // Explicit wrap so non-power-of-two depths would also be safe.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = slot_q[rd_ptr_q];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      slot_d[wr_ptr_q] = push_owner_i;
      wr_ptr_d         = next_ptr(wr_ptr_q);
    end
    if (w_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_req_arbiter                                        |
// | Description : Merges an instruction-fetch port and a load/store port |
// |               onto one shared memory request channel. Selection is   |
// |               locked while a request waits for mem_addr_ok; accepted |
// |               owners are queued in order so each mem_data_ok is      |
// |               returned to the right requester.                       |
// | Config      : ARB_RR_EN - when defined, simultaneous requests are    |
// |               granted round robin; otherwise data always wins ties.  |
// | Ports       : clk, resetn          - clock / sync active-low reset   |
// |               inst_req/addr        - fetch request (always a word)   |
// |               inst_addr_ok/data_ok - fetch accept / response strobes |
// |               inst_rdata           - fetch read data                 |
// |               data_req/size/wstrb/addr/wdata - load/store request    |
// |               data_addr_ok/data_ok/rdata     - load/store handshake  |
// |               mem_req/size/wstrb/addr/wdata  - shared request out    |
// |               mem_addr_ok/data_ok/rdata      - shared memory return  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_req_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // load/store port
  input  logic        data_req,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared memory channel
  output logic        mem_req,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  import mem_arb_pkg::*;

  logic [LOCK_W-1:0] lock_q, lock_d;

  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_fifo_head;
  logic w_sel;
  logic w_tie_owner;
  logic w_accept;
  logic w_pop;

  // ------------------------------------------------------------------
  // Tie-break policy
  // ------------------------------------------------------------------
`ifdef ARB_RR_EN
  // rr_q holds the owner to favour on the next tie; it flips to the
  // other requester whenever a request is accepted.
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (w_accept) begin
      rr_d = ~w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_q <= OWNER_INST;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign w_tie_owner = rr_q;
`else
  assign w_tie_owner = OWNER_DATA;
`endif

  // ------------------------------------------------------------------
  // Request lock: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q <= LOCK_IDLE;
    end else begin
      lock_q <= lock_d;
    end
  end

  // ------------------------------------------------------------------
  // Request lock: next state. A request left unaccepted pins the
  // current selection; acceptance or a withdrawn request releases it.
  // ------------------------------------------------------------------
  always_comb begin
    lock_d = LOCK_IDLE;
    if (mem_req && !mem_addr_ok) begin
      lock_d = lock_state_for(w_sel);
    end
  end

  // ------------------------------------------------------------------
  // Request lock: output (owner selection). A lock only binds while
  // its owner is still requesting, so a withdrawn request cannot stall
  // the other port.
  // ------------------------------------------------------------------
  always_comb begin
    w_sel = OWNER_INST;
    if ((lock_q == LOCK_INST) && inst_req) begin
      w_sel = OWNER_INST;
    end else if ((lock_q == LOCK_DATA) && data_req) begin
      w_sel = OWNER_DATA;
    end else if (inst_req && data_req) begin
      w_sel = w_tie_owner;
    end else if (data_req) begin
      w_sel = OWNER_DATA;
    end else begin
      w_sel = OWNER_INST;
    end
  end

  // ------------------------------------------------------------------
  // Shared request channel. Full comes from the registered count, so
  // a response popping this cycle does not reopen the channel until
  // the next one.
  // ------------------------------------------------------------------
  assign mem_req   = (inst_req | data_req) & ~w_fifo_full & resetn;
  assign w_accept  = mem_req & mem_addr_ok;

  assign mem_size  = (w_sel == OWNER_DATA) ? data_size  : SIZE_W;
  assign mem_wstrb = (w_sel == OWNER_DATA) ? data_wstrb : 4'b0000;
  assign mem_addr  = (w_sel == OWNER_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (w_sel == OWNER_DATA) ? data_wdata : 32'h0000_0000;

  assign inst_addr_ok = w_accept & (w_sel == OWNER_INST);
  assign data_addr_ok = w_accept & (w_sel == OWNER_DATA);

  // ------------------------------------------------------------------
  // Response steering. A response with nothing outstanding is dropped;
  // this also swallows late responses to transactions flushed by reset.
  // ------------------------------------------------------------------
  assign w_pop = mem_data_ok & ~w_fifo_empty & resetn;

  assign inst_data_ok = w_pop & (w_fifo_head == OWNER_INST);
  assign data_data_ok = w_pop & (w_fifo_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  arb_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (w_accept),
    .push_owner_i (w_sel),
    .pop_i        (w_pop),
    .full_o       (w_fifo_full),
    .empty_o      (w_fifo_empty),
    .head_o       (w_fifo_head)
  );

endmodule
`default_nettype wire
